// File: rtl/sigmoid_backprop_pkg.sv
// Shared Q8.8 constants, multiplier sizing and FSM encoding for the sigmoid
// backpropagation block.
package sigmoid_backprop_pkg;

  localparam int Q_W       = 16;
  localparam int FRAC_BITS = 8;
  localparam logic [Q_W-1:0] ONE = 16'h0100;

  // One multiplier serves both products: s*(1-s) needs a 9-bit multiplier and
  // e*d a 16-bit signed multiplicand; 24 accumulator bits hold either result.
  localparam int MUL_A_W   = Q_W;
  localparam int MUL_B_W   = 9;
  localparam int MUL_P_W   = Q_W + FRAC_BITS;
  localparam int MUL_CNT_W = $clog2(MUL_B_W + 1);

  localparam logic [MUL_CNT_W-1:0] STEPS_D = MUL_CNT_W'(9);
  localparam logic [MUL_CNT_W-1:0] STEPS_E = MUL_CNT_W'(7);

  typedef enum logic [1:0] {
    IDLE,
    MUL_D,
    MUL_E,
    DONE
  } state_t;

endpackage

// File: rtl/seq_shift_add_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, LSB first.
// The multiplicand may be signed; the multiplier is always unsigned.
module seq_shift_add_mul #(
  parameter int A_W      = 16,
  parameter int B_W      = 9,
  parameter int P_W      = 24,
  parameter int SHIFT    = 8,
  parameter bit SIGNED_A = 1'b1,
  parameter int CNT_W    = $clog2(B_W + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  input  logic [CNT_W-1:0]   steps,
  output logic               busy,
  output logic               done,
  output logic [P_W-SHIFT-1:0] product
);

  logic [A_W-1:0]   a_q;
  logic [B_W-1:0]   b_q;
  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] steps_q;
  logic [P_W-1:0]   acc_q;
  logic             busy_q;
  logic             done_q;

  function automatic logic [P_W-1:0] partial(input logic [A_W-1:0] m,
                                             input logic           bit_v,
                                             input logic [CNT_W-1:0] sh);
    logic [P_W-1:0] ext;
    ext = {{(P_W-A_W){SIGNED_A & m[A_W-1]}}, m};
    return bit_v ? (ext << sh) : '0;
  endfunction

  // The start edge already performs step 0, so a product of N bits takes
  // exactly N edges; done pulses for one cycle after the last step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      steps_q <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done_q <= 1'b0;
      if (start) begin
        a_q     <= a;
        b_q     <= b;
        steps_q <= steps;
        idx_q   <= CNT_W'(1);
        acc_q   <= partial(a, b[0], '0);
        busy_q  <= (steps > CNT_W'(1));
        done_q  <= (steps == CNT_W'(1));
      end else if (busy_q) begin
        acc_q <= acc_q + partial(a_q, b_q[idx_q], idx_q);
        idx_q <= idx_q + CNT_W'(1);
        if (idx_q == steps_q - CNT_W'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = acc_q[P_W-1:SHIFT];

endmodule

// File: rtl/sigmoid_backprop.sv
// Sigmoid derivative backprop: delta = e * s * (1 - s) in Q8.8, computed with
// one shared iterative multiplier and a valid/ready handshake on both sides.
module sigmoid_backprop
  import sigmoid_backprop_pkg::*;
#(
  parameter int DATA_W = Q_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] sig_in,
  input  logic [DATA_W-1:0] err_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] delta_out
);

  state_t state_q, state_d;

  logic [DATA_W-1:0]    s_q, e_q, delta_q, s_cl;
  logic                 mul_start, mul_sel_e, mul_busy, mul_done;
  logic [DATA_W-1:0]    mul_a;
  logic [MUL_B_W-1:0]   mul_b;
  logic [MUL_CNT_W-1:0] mul_steps;
  logic [DATA_W-1:0]    mul_p;

  // Negative s reads as 0, anything past 1.0 as 1.0.
  always_comb begin
    if (s_q[DATA_W-1])  s_cl = '0;
    else if (s_q > ONE) s_cl = ONE;
    else                s_cl = s_q;
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch.
    state_d   = state_q;
    mul_start = 1'b0;
    mul_sel_e = 1'b0;
    case (state_q)
      IDLE:  if (in_valid) state_d = MUL_D;
      MUL_D: begin
        if (mul_done) begin
          mul_start = 1'b1;
          mul_sel_e = 1'b1;
          state_d   = MUL_E;
        end else if (!mul_busy) begin
          mul_start = 1'b1;
        end
      end
      MUL_E: if (mul_done)  state_d = DONE;
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // In MUL_E the multiplier is fed d = p >> 8 straight from its own output.
  assign mul_a     = mul_sel_e ? e_q : s_cl;
  assign mul_b     = mul_sel_e ? {2'b00, mul_p[6:0]} : MUL_B_W'(ONE - s_cl);
  assign mul_steps = mul_sel_e ? STEPS_E : STEPS_D;

  seq_shift_add_mul #(
    .A_W      (MUL_A_W),
    .B_W      (MUL_B_W),
    .P_W      (MUL_P_W),
    .SHIFT    (FRAC_BITS),
    .SIGNED_A (1'b1),
    .CNT_W    (MUL_CNT_W)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (mul_a),
    .b       (mul_b),
    .steps   (mul_steps),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_p)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      e_q     <= '0;
      delta_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid) begin
        s_q <= sig_in;
        e_q <= err_in;
      end
      // Bits [23:8] of the signed product are the floor of (e*d) / 256.
      if (state_q == MUL_E && mul_done) delta_q <= mul_p;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign delta_out = delta_q;

endmodule
